// File: rtl/int_vector_seq.sv
// int_vector_seq: 6502 RESET/NMI/IRQ/BRK arbiter and 7-state vector sequencer driving the ADH/ADL constant pulls.
// Define INT_VEC_HIJACK_EN to let an NMI arriving mid-sequence steal an in-flight IRQ/BRK vector fetch.
module int_vector_seq #(
  parameter int NMI_SYNC_STAGES = 2,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       CE,
  input  logic       SYNC,
  input  logic       BRK_REQ,
  input  logic       NMI_N,
  input  logic       IRQ_N,
  input  logic       I_FLAG,
  output logic       FORCE_BRK,
  output logic       INT_ACTIVE,
  output logic       ADH_SIG_ZERO,
  output logic       ADH_SIG_OTHER,
  output logic       ADL_SIG0,
  output logic       ADL_SIG1,
  output logic       ADL_SIG2,
  output logic       PUSH_WE,
  output logic       SP_DEC,
  output logic       B_OUT,
  output logic       VEC_LOAD_L,
  output logic       VEC_LOAD_H,
  output logic       SET_I,
  output logic [1:0] VEC_SEL
);
  typedef enum logic [2:0] {S_IDLE, S_D1, S_D2, S_PCH, S_PCL, S_P, S_VL, S_VH} state_t;
  localparam logic [1:0] SEL_NMI = 2'b01, SEL_RES = 2'b10, SEL_IRQ = 2'b11;
  state_t state, next;
  logic [NMI_SYNC_STAGES-1:0] nmi_sync;
  logic [IRQ_SYNC_STAGES-1:0] irq_sync;
  logic nmi_prev, nmi_pend, res_pend, b_flag;
  logic [1:0] vec_sel;
  logic nmi_edge, irq_act, hw_req, take, push, vec;
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) begin
      nmi_sync <= '1;
      irq_sync <= '1;
    end else begin
      nmi_sync <= NMI_SYNC_STAGES'({nmi_sync, NMI_N});
      irq_sync <= IRQ_SYNC_STAGES'({irq_sync, IRQ_N});
    end
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) state <= S_IDLE;
    else state <= next;
  always_comb begin
    nmi_edge = CE & nmi_prev & ~nmi_sync[NMI_SYNC_STAGES-1];
    irq_act = ~irq_sync[IRQ_SYNC_STAGES-1] & ~I_FLAG;
    hw_req = res_pend | nmi_pend | irq_act;
    take = RES_N & CE & SYNC & (state == S_IDLE) & (hw_req | BRK_REQ);
    push = state inside {S_PCH, S_PCL, S_P};
    vec = state inside {S_VL, S_VH};
    next = !CE ? state : state == S_IDLE ? (take ? S_D1 : S_IDLE) : state == S_VH ? S_IDLE : state_t'(state + 3'd1);
    FORCE_BRK = take & hw_req;
    INT_ACTIVE = state != S_IDLE;
    // ADH=01 (stack page) while pushing, FF otherwise; the all-zero page is never needed here
    ADH_SIG_ZERO = 1'b0;
    ADH_SIG_OTHER = push;
    ADL_SIG0 = state == S_VL;
    ADL_SIG1 = vec & (vec_sel == SEL_RES);
    ADL_SIG2 = vec & (vec_sel == SEL_NMI);
    PUSH_WE = CE & push & (vec_sel != SEL_RES);
    SP_DEC = CE & push;
    VEC_LOAD_L = CE & (state == S_VL);
    VEC_LOAD_H = CE & (state == S_VH);
    SET_I = CE & (state == S_VL);
    B_OUT = b_flag;
    VEC_SEL = vec_sel;
  end
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
      res_pend <= 1'b1;
      vec_sel <= 2'b00;
      b_flag <= 1'b0;
    end else if (CE) begin
      nmi_prev <= nmi_sync[NMI_SYNC_STAGES-1];
      // a fresh edge in the clearing cycle keeps the NMI pending
      nmi_pend <= nmi_edge | (nmi_pend & ~((state == S_VL) & (vec_sel == SEL_NMI)));
      if (state == S_VH && vec_sel == SEL_RES) res_pend <= 1'b0;
      if (take) begin
        vec_sel <= res_pend ? SEL_RES : nmi_pend ? SEL_NMI : SEL_IRQ;
        b_flag <= ~hw_req;
      end else if (state == S_VH) begin
        vec_sel <= 2'b00;
        b_flag <= 1'b0;
      end
`ifdef INT_VEC_HIJACK_EN
      else if (state inside {S_D1, S_D2, S_PCH, S_PCL, S_P} && vec_sel == SEL_IRQ && (nmi_pend || nmi_edge))
        vec_sel <= SEL_NMI;
`endif
    end
endmodule

// File: tb/tb_int_vector_seq.sv
// tb_int_vector_seq: directed test-plan scenarios plus random pin/CE/SYNC traffic, checked every cycle
// against a model that expands each taken interrupt into a queue of bus-cycle kinds.
module tb_int_vector_seq;
  localparam int NS = 2, IS = 2;
  localparam int K_D = 0, K_P = 1, K_VL = 2, K_VH = 3;
  logic clk = 0, res_n = 1, ce = 0, sync = 0, brk_req = 0, nmi_n = 1, irq_n = 1, i_flag = 1;
  logic force_brk, int_active, adh_zero, adh_other, adl0, adl1, adl2;
  logic push_we, sp_dec, b_out, vload_l, vload_h, set_i;
  logic [1:0] vec_sel;
  int n_checks = 0, n_fail = 0, cnt_push = 0, cnt_dec = 0;
  int q[$];
  bit nmi_h[$], irq_h[$];
  bit m_res, m_nmi, m_prev, m_b;
  logic [1:0] m_sel;
  always #5 clk = ~clk;
  int_vector_seq #(.NMI_SYNC_STAGES(NS), .IRQ_SYNC_STAGES(IS)) dut (
    .CLK(clk), .RES_N(res_n), .CE(ce), .SYNC(sync), .BRK_REQ(brk_req), .NMI_N(nmi_n), .IRQ_N(irq_n),
    .I_FLAG(i_flag), .FORCE_BRK(force_brk), .INT_ACTIVE(int_active), .ADH_SIG_ZERO(adh_zero),
    .ADH_SIG_OTHER(adh_other), .ADL_SIG0(adl0), .ADL_SIG1(adl1), .ADL_SIG2(adl2), .PUSH_WE(push_we),
    .SP_DEC(sp_dec), .B_OUT(b_out), .VEC_LOAD_L(vload_l), .VEC_LOAD_H(vload_h), .SET_I(set_i),
    .VEC_SEL(vec_sel)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q = {};
    m_res = 1; m_nmi = 0; m_prev = 1; m_b = 0; m_sel = 2'b00;
    nmi_h = {}; irq_h = {};
    repeat (NS) nmi_h.push_back(1'b1);
    repeat (IS) irq_h.push_back(1'b1);
  endtask
  task automatic compare();
    bit act = q.size() != 0;
    int k = act ? q[0] : -1;
    bit hw = m_res || m_nmi || (!irq_h[0] && !i_flag);
    logic [7:0] base = m_sel == 2'b01 ? 8'hFA : m_sel == 2'b10 ? 8'hFC : 8'hFE;
    logic [7:0] adl_e = k == K_VL ? base : k == K_VH ? base + 8'd1 : 8'hFF;
    logic [7:0] adh_e = k == K_P ? 8'h01 : 8'hFF;
    logic [7:0] adh_g = adh_zero ? 8'h00 : adh_other ? 8'h01 : 8'hFF;
    logic [4:0] stb_e = ce ? {k == K_P && m_sel != 2'b10, k == K_P, k == K_VL, k == K_VH, k == K_VL} : 5'b0;
    check("adh", {8'h0, adh_g}, {8'h0, adh_e});
    check("adl", {8'h0, 5'b11111, ~adl2, ~adl1, ~adl0}, {8'h0, adl_e});
    check("strobes", {11'b0, push_we, sp_dec, vload_l, vload_h, set_i}, {11'b0, stb_e});
    check("ctrl", {11'b0, force_brk, int_active, vec_sel, b_out},
          {11'b0, !act && sync && ce && res_n && hw, act, act ? m_sel : 2'b00, act && m_b});
    cnt_push += int'(push_we);
    cnt_dec += int'(sp_dec);
  endtask
  task automatic model_step();
    bit e, hw;
    int k;
    if (!res_n) return;
    hw = m_res || m_nmi || (!irq_h[0] && !i_flag);
    if (ce) begin
      e = m_prev && !nmi_h[0];
      m_prev = nmi_h[0];
      if (q.size() != 0) begin
        k = q.pop_front();
        if (k == K_VL && m_sel == 2'b01) m_nmi = 0;
        if (k == K_VH && m_sel == 2'b10) m_res = 0;
`ifdef INT_VEC_HIJACK_EN
        if (k <= K_P && m_sel == 2'b11 && (m_nmi || e)) m_sel = 2'b01;
`endif
      end else if (sync && (hw || brk_req)) begin
        m_sel = m_res ? 2'b10 : m_nmi ? 2'b01 : 2'b11;
        m_b = !hw;
        q = {K_D, K_D, K_P, K_P, K_P, K_VL, K_VH};
      end
      if (e) m_nmi = 1;
    end
    nmi_h.push_back(nmi_n); void'(nmi_h.pop_front());
    irq_h.push_back(irq_n); void'(irq_h.pop_front());
  endtask
  task automatic tick(input bit ce_i, input bit sync_i, input bit brk_i);
    ce = ce_i; sync = sync_i; brk_req = brk_i;
    @(negedge clk);
    #2;
    if (!res_n) model_reset();
    compare();
    @(posedge clk);
    #1;
    model_step();
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1, 0, 0);
  endtask
  initial begin
    #1 res_n = 0;
    repeat (3) tick(1, 0, 0);
    res_n = 1;
    idle(3);
    cnt_push = 0; cnt_dec = 0;
    tick(1, 1, 0);
    idle(8);
    check("rst_push_cnt", 16'(cnt_push), 16'd0);
    check("rst_dec_cnt", 16'(cnt_dec), 16'd3);
    tick(1, 1, 0);
    idle(2);
    irq_n = 0; i_flag = 0;
    idle(3);
    cnt_push = 0;
    tick(1, 1, 0);
    i_flag = 1;
    idle(8);
    check("irq_push_cnt", 16'(cnt_push), 16'd3);
    tick(1, 1, 0);
    idle(2);
    i_flag = 0; nmi_n = 0;
    idle(4);
    tick(1, 1, 0);
    idle(8);
    tick(1, 1, 0);
    idle(8);
    nmi_n = 1; irq_n = 1; i_flag = 1;
    idle(4);
    tick(1, 1, 1);
    tick(1, 0, 0);
    nmi_n = 0;
    idle(8);
    tick(1, 1, 0);
    idle(8);
    nmi_n = 1;
    idle(4);
    cnt_push = 0;
    tick(1, 1, 1);
    idle(3);
    repeat (3) tick(0, 0, 0);
    idle(8);
    check("stall_push_cnt", 16'(cnt_push), 16'd3);
    tick(1, 1, 1);
    idle(4);
    res_n = 0;
    tick(1, 0, 0);
    tick(1, 1, 0);
    res_n = 1;
    idle(2);
    cnt_push = 0; cnt_dec = 0;
    tick(1, 1, 0);
    idle(8);
    check("rst2_push_cnt", 16'(cnt_push), 16'd0);
    check("rst2_dec_cnt", 16'(cnt_dec), 16'd3);
    for (int i = 0; i < 3000; i++) begin
      res_n = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, 19) == 0) nmi_n = ~nmi_n;
      if ($urandom_range(0, 29) == 0) irq_n = ~irq_n;
      if ($urandom_range(0, 15) == 0) i_flag = ~i_flag;
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
